// File: rtl/sparc_win_pkg.sv
// Shared definitions for the register-window spill/fill unit: FSM states,
// frame geometry and the windowed register-file index mapping.
package sparc_win_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECIDE  = 3'd1,
        ST_SP_RD   = 3'd2,
        ST_SP_WAIT = 3'd3,
        ST_FL_REQ  = 3'd4,
        ST_FL_WAIT = 3'd5,
        ST_COMMIT  = 3'd6
    } win_state_t;

    localparam int FRAME_WORDS = 16;
    localparam int FRAME_BYTES = 64;
    localparam int WORD_BYTES  = 4;
    localparam int N_GLOBALS   = 8;
    localparam int REG_OUT0    = 8;
    localparam int REG_LOCAL0  = 16;
    localparam int REG_IN0     = 24;
    localparam int RF_ADDR_W   = 7;

    // Physical index of architectural register r (0..31) in window w.
    // Outs and locals of w sit in block w; the ins of w alias the outs of w+1.
    function automatic logic [RF_ADDR_W-1:0] win_phys_idx(input int w, input int r, input int nwin);
        int idx;
        int nxt;
        nxt = (w + 1 >= nwin) ? 0 : w + 1;
        if (r < REG_OUT0)
            idx = r;
        else if (r < REG_IN0)
            idx = N_GLOBALS + FRAME_WORDS * w + (r - REG_OUT0);
        else
            idx = N_GLOBALS + FRAME_WORDS * nxt + (r - REG_IN0);
        return RF_ADDR_W'(idx);
    endfunction

endpackage

// File: rtl/win_mod_arith.sv
// Modulo-NWINDOWS neighbours of the current window pointer and their one-hot masks.
module win_mod_arith #(
    parameter int NWINDOWS = 4,
    parameter int CWP_W    = 5
) (
    input  logic [CWP_W-1:0]    cwp,
    output logic [CWP_W-1:0]    cwp_dec1,
    output logic [CWP_W-1:0]    cwp_dec2,
    output logic [CWP_W-1:0]    cwp_inc1,
    output logic [CWP_W-1:0]    cwp_inc2,
    output logic [NWINDOWS-1:0] oh_dec1,
    output logic [NWINDOWS-1:0] oh_dec2,
    output logic [NWINDOWS-1:0] oh_inc1,
    output logic [NWINDOWS-1:0] oh_inc2
);

    int c, d1, d2, i1, i2;

    // Wrap arithmetic assumes cwp is already in 0..NWINDOWS-1.
    always_comb begin
        c  = int'(cwp);
        d1 = (c >= 1) ? c - 1 : c + NWINDOWS - 1;
        d2 = (c >= 2) ? c - 2 : c + NWINDOWS - 2;
        i1 = (c + 1 >= NWINDOWS) ? c + 1 - NWINDOWS : c + 1;
        i2 = (c + 2 >= NWINDOWS) ? c + 2 - NWINDOWS : c + 2;
    end

    assign cwp_dec1 = CWP_W'(d1);
    assign cwp_dec2 = CWP_W'(d2);
    assign cwp_inc1 = CWP_W'(i1);
    assign cwp_inc2 = CWP_W'(i2);

    assign oh_dec1 = NWINDOWS'(1) << cwp_dec1;
    assign oh_dec2 = NWINDOWS'(1) << cwp_dec2;
    assign oh_inc1 = NWINDOWS'(1) << cwp_inc1;
    assign oh_inc2 = NWINDOWS'(1) << cwp_inc2;

endmodule

// File: rtl/window_spill_fill_unit.sv
// SAVE/RESTORE window manager: owns CWP/WIM, traps or self-services
// overflow/underflow by spilling/filling the 16-word victim frame via RAM.
//
// state      | meaning
// IDLE       | waiting for a request; fast SAVE/RESTORE and traps resolve here
// DECIDE     | victim/target frame latched, choose spill or fill
// SP_RD      | read register file, capture write data
// SP_WAIT    | RAM write outstanding until mem_mfc
// FL_REQ     | one-cycle gap before the next RAM read
// FL_WAIT    | RAM read outstanding; on mem_mfc write the register file
// COMMIT     | apply new cwp/wim, pulse done
module window_spill_fill_unit
    import sparc_win_pkg::*;
#(
    parameter int          NWINDOWS  = 4,
    parameter int          CWP_W     = 5,
    parameter logic [31:0] SAVE_BASE = 32'h180,
    parameter int          DATA_W    = 32
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 save_req,
    input  logic                 rest_req,
    input  logic                 auto_mode,
    input  logic                 wim_wr,
    input  logic [NWINDOWS-1:0]  wim_in,
    output logic [CWP_W-1:0]     cwp,
    output logic [NWINDOWS-1:0]  wim,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf_trap,
    output logic                 unf_trap,
    output logic                 req_err,
    output logic [6:0]           rf_addr,
    input  logic [DATA_W-1:0]    rf_rdata,
    output logic                 rf_we,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 mem_en,
    output logic                 mem_rw,
    output logic [DATA_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_mfc
);

    win_state_t state, state_nxt;

    logic [CWP_W-1:0]    cwp_q, frame_q, new_cwp_q;
    logic [NWINDOWS-1:0] wim_q, new_wim_q;
    logic [3:0]          k_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                is_spill_q;
    logic                done_q, ovf_q, unf_q, err_q;

    logic [CWP_W-1:0]    cwp_dec1, cwp_dec2, cwp_inc1, cwp_inc2;
    logic [NWINDOWS-1:0] oh_dec1, oh_dec2, oh_inc1, oh_inc2;

    win_mod_arith #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W)) u_arith (
        .cwp      (cwp_q),
        .cwp_dec1 (cwp_dec1),
        .cwp_dec2 (cwp_dec2),
        .cwp_inc1 (cwp_inc1),
        .cwp_inc2 (cwp_inc2),
        .oh_dec1  (oh_dec1),
        .oh_dec2  (oh_dec2),
        .oh_inc1  (oh_inc1),
        .oh_inc2  (oh_inc2)
    );

    // Request acceptance: only in IDLE, WRWIM beats requests, both requests is an error.
    logic idle, wim_take, req_take, err_take, ovf, unf;
    logic save_ok, rest_ok, trap_ovf, trap_unf, go_spill, go_fill, last_word, mfc_wait;

    assign idle      = (state == ST_IDLE);
    assign wim_take  = idle & wim_wr;
    assign req_take  = idle & ~wim_wr & (save_req ^ rest_req);
    assign err_take  = idle & ~wim_wr & save_req & rest_req;
    assign ovf       = |(wim_q & oh_dec1);
    assign unf       = |(wim_q & oh_inc1);
    assign save_ok   = req_take & save_req & ~ovf;
    assign rest_ok   = req_take & rest_req & ~unf;
    assign trap_ovf  = req_take & save_req & ovf & ~auto_mode;
    assign trap_unf  = req_take & rest_req & unf & ~auto_mode;
    assign go_spill  = req_take & save_req & ovf & auto_mode;
    assign go_fill   = req_take & rest_req & unf & auto_mode;
    assign last_word = (k_q == 4'(FRAME_WORDS - 1));
    assign mfc_wait  = mem_mfc & ((state == ST_SP_WAIT) | (state == ST_FL_WAIT));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (go_spill || go_fill) state_nxt = ST_DECIDE;
            ST_DECIDE:  state_nxt = is_spill_q ? ST_SP_RD : ST_FL_REQ;
            ST_SP_RD:   state_nxt = ST_SP_WAIT;
            ST_SP_WAIT: if (mem_mfc) state_nxt = last_word ? ST_COMMIT : ST_SP_RD;
            ST_FL_REQ:  state_nxt = ST_FL_WAIT;
            ST_FL_WAIT: if (mem_mfc) state_nxt = last_word ? ST_COMMIT : ST_FL_REQ;
            ST_COMMIT:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; mem_en falls with the async state reset.
    always_comb begin
        busy      = (state != ST_IDLE);
        done      = done_q | (state == ST_COMMIT);
        mem_en    = (state == ST_SP_WAIT) | (state == ST_FL_WAIT);
        mem_rw    = (state == ST_SP_WAIT);
        rf_we     = (state == ST_FL_WAIT) & mem_mfc;
        rf_wdata  = mem_rdata;
        rf_addr   = win_phys_idx(int'(frame_q), REG_LOCAL0 + int'(k_q), NWINDOWS);
        mem_addr  = DATA_W'(SAVE_BASE) + DATA_W'(FRAME_BYTES) * DATA_W'(frame_q)
                    + DATA_W'(WORD_BYTES) * DATA_W'(k_q);
        mem_wdata = wdata_q;
    end

    // Frame bookkeeping: victim/target frame, pending commit values, word index, spill data.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_q    <= '0;
            new_cwp_q  <= '0;
            new_wim_q  <= '0;
            is_spill_q <= 1'b0;
            k_q        <= '0;
            wdata_q    <= '0;
        end else begin
            if (go_spill) begin
                frame_q    <= cwp_dec2;
                new_cwp_q  <= cwp_dec1;
                new_wim_q  <= oh_dec2;
                is_spill_q <= 1'b1;
                k_q        <= '0;
            end else if (go_fill) begin
                frame_q    <= cwp_inc1;
                new_cwp_q  <= cwp_inc1;
                new_wim_q  <= oh_inc2;
                is_spill_q <= 1'b0;
                k_q        <= '0;
            end else if (mfc_wait) begin
                k_q <= k_q + 4'd1;
            end
            if (state == ST_SP_RD) wdata_q <= rf_rdata;
        end
    end

    // Architectural CWP/WIM: WRWIM, fast SAVE/RESTORE, or commit after spill/fill.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cwp_q <= CWP_W'(NWINDOWS - 1);
            wim_q <= NWINDOWS'(1);
        end else if (wim_take) begin
            wim_q <= wim_in;
        end else if (save_ok) begin
            cwp_q <= cwp_dec1;
        end else if (rest_ok) begin
            cwp_q <= cwp_inc1;
        end else if (state == ST_COMMIT) begin
            cwp_q <= new_cwp_q;
            wim_q <= new_wim_q;
        end
    end

    // One-cycle strobes for the paths that resolve straight from IDLE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= save_ok | rest_ok | trap_ovf | trap_unf;
            ovf_q  <= trap_ovf;
            unf_q  <= trap_unf;
            err_q  <= err_take;
        end
    end

    assign cwp      = cwp_q;
    assign wim      = wim_q;
    assign ovf_trap = ovf_q;
    assign unf_trap = unf_q;
    assign req_err  = err_q;

endmodule

// File: tb/tb_window_spill_fill_unit.sv
// Directed bench for window_spill_fill_unit with NWINDOWS=4 and a behavioural RAM/RF.
module tb_window_spill_fill_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        save_req, rest_req, auto_mode, wim_wr;
    logic [3:0]  wim_in, wim;
    logic [4:0]  cwp;
    logic        busy, done, ovf_trap, unf_trap, req_err;
    logic [6:0]  rf_addr;
    logic [31:0] rf_rdata, rf_wdata, mem_addr, mem_wdata, mem_rdata;
    logic        rf_we, mem_en, mem_rw, mem_mfc;

    int checks = 0;
    int failures = 0;
    int mfc_delay = 0;
    int wait_cnt = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] rd_addr[$];
    logic [6:0]  rfw_addr[$];
    logic [31:0] rfw_data[$];

    always #5 Clk = ~Clk;

    assign rf_rdata = 32'hC0DE_0000 | {25'd0, rf_addr};

    window_spill_fill_unit #(
        .NWINDOWS(4), .CWP_W(5), .SAVE_BASE(32'h180), .DATA_W(32)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .save_req(save_req), .rest_req(rest_req), .auto_mode(auto_mode),
        .wim_wr(wim_wr), .wim_in(wim_in),
        .cwp(cwp), .wim(wim), .busy(busy), .done(done),
        .ovf_trap(ovf_trap), .unf_trap(unf_trap), .req_err(req_err),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_mfc(mem_mfc)
    );

    // RAM responder: mem_mfc one cycle after mfc_delay wait cycles, logging each transfer.
    initial begin
        mem_mfc = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge Clk);
            if (mem_mfc) begin
                mem_mfc = 1'b0;
                wait_cnt = 0;
            end else if (mem_en) begin
                if (wait_cnt >= mfc_delay) begin
                    mem_mfc = 1'b1;
                    if (mem_rw) begin
                        wr_addr.push_back(mem_addr);
                        wr_data.push_back(mem_wdata);
                    end else begin
                        rd_addr.push_back(mem_addr);
                        mem_rdata = 32'hF00D_0000 | (mem_addr & 32'h0000_FFFF);
                    end
                    #1;
                    if (rf_we) begin
                        rfw_addr.push_back(rf_addr);
                        rfw_data.push_back(rf_wdata);
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Issue one request; lat = number of cycles until done is seen, -1 on timeout.
    task automatic issue(input logic s, input logic r, input logic a, input int budget, output int lat);
        @(negedge Clk);
        save_req = s; rest_req = r; auto_mode = a;
        @(negedge Clk);
        save_req = 0; rest_req = 0; auto_mode = 0;
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic apply_reset();
        Reset_n = 0;
        repeat (3) @(negedge Clk);
        Reset_n = 1;
    endtask

    task automatic test_reset();
        save_req = 0; rest_req = 0; auto_mode = 0; wim_wr = 0; wim_in = '0;
        Reset_n = 0;
        repeat (3) @(negedge Clk);
        checks++; if (cwp !== 5'd3) begin failures++; $display("FAIL reset_cwp got=%0d exp=3", cwp); end
        checks++; if (wim !== 4'b0001) begin failures++; $display("FAIL reset_wim got=%b exp=0001", wim); end
        checks++; if (busy !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL reset_busy_mem_en got=%b%b exp=00", busy, mem_en); end
        checks++; if (done !== 1'b0 || rf_we !== 1'b0 || req_err !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b%b exp=000", done, rf_we, req_err); end
        Reset_n = 1;
        @(negedge Clk);
    endtask

    task automatic test_save_simple();
        int lat;
        issue(1, 0, 0, 5, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL save1_latency got=%0d exp=1", lat); end
        checks++; if (cwp !== 5'd2) begin failures++; $display("FAIL save1_cwp got=%0d exp=2", cwp); end
        checks++; if (ovf_trap !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL save1_no_trap got=%b%b exp=00", ovf_trap, busy); end
        issue(1, 0, 0, 5, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL save2_latency got=%0d exp=1", lat); end
        checks++; if (cwp !== 5'd1) begin failures++; $display("FAIL save2_cwp got=%0d exp=1", cwp); end
    endtask

    task automatic test_ovf_trap();
        int lat;
        issue(1, 0, 0, 5, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL ovf_latency got=%0d exp=1", lat); end
        checks++; if (ovf_trap !== 1'b1) begin failures++; $display("FAIL ovf_trap got=%b exp=1", ovf_trap); end
        checks++; if (cwp !== 5'd1 || wim !== 4'b0001) begin failures++; $display("FAIL ovf_state got=%0d/%b exp=1/0001", cwp, wim); end
        @(negedge Clk);
        checks++; if (ovf_trap !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL ovf_pulse_width got=%b%b exp=00", ovf_trap, done); end
    endtask

    task automatic test_spill();
        int lat;
        logic [31:0] ea, ed;
        wr_addr.delete(); wr_data.delete();
        mfc_delay = 0;
        @(negedge Clk);
        save_req = 1; auto_mode = 1;
        @(negedge Clk);
        save_req = 0; auto_mode = 0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL spill_busy got=%b exp=1", busy); end
        // WRWIM while busy must be ignored
        wim_wr = 1; wim_in = 4'b0000;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge Clk);
            wim_wr = 0;
        end
        checks++; if (lat !== 34) begin failures++; $display("FAIL spill_latency got=%0d exp=34", lat); end
        checks++; if (wr_addr.size() !== 16) begin failures++; $display("FAIL spill_count got=%0d exp=16", wr_addr.size()); end
        for (int k = 0; k < 16 && k < wr_addr.size(); k++) begin
            ea = 32'h240 + 32'(4 * k);
            ed = 32'hC0DE_0000 | 32'((k < 8) ? 64 + k : k);
            checks++; if (wr_addr[k] !== ea) begin failures++; $display("FAIL spill_addr[%0d] got=%h exp=%h", k, wr_addr[k], ea); end
            checks++; if (wr_data[k] !== ed) begin failures++; $display("FAIL spill_data[%0d] got=%h exp=%h", k, wr_data[k], ed); end
        end
        @(negedge Clk);
        checks++; if (cwp !== 5'd0) begin failures++; $display("FAIL spill_cwp got=%0d exp=0", cwp); end
        checks++; if (wim !== 4'b1000) begin failures++; $display("FAIL spill_wim got=%b exp=1000", wim); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL spill_idle got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_wim_write();
        int lat;
        @(negedge Clk);
        wim_wr = 1; wim_in = 4'b0001; rest_req = 1;
        @(negedge Clk);
        wim_wr = 0; rest_req = 0;
        checks++; if (wim !== 4'b0001) begin failures++; $display("FAIL wimwr_wim got=%b exp=0001", wim); end
        checks++; if (cwp !== 5'd0 || done !== 1'b0) begin failures++; $display("FAIL wimwr_req_dropped got=%0d/%b exp=0/0", cwp, done); end
        issue(1, 0, 0, 5, lat);
        checks++; if (lat !== 1 || cwp !== 5'd3) begin failures++; $display("FAIL save_wrap got=%0d/%0d exp=1/3", lat, cwp); end
    endtask

    task automatic test_fill();
        int lat;
        logic [31:0] ea;
        rd_addr.delete(); rfw_addr.delete(); rfw_data.delete();
        mfc_delay = 3;
        issue(0, 1, 1, 200, lat);
        checks++; if (lat !== 82) begin failures++; $display("FAIL fill_latency got=%0d exp=82", lat); end
        checks++; if (rd_addr.size() !== 16 || rfw_addr.size() !== 16) begin failures++; $display("FAIL fill_count got=%0d/%0d exp=16/16", rd_addr.size(), rfw_addr.size()); end
        for (int k = 0; k < 16 && k < rd_addr.size() && k < rfw_addr.size(); k++) begin
            ea = 32'h180 + 32'(4 * k);
            checks++; if (rd_addr[k] !== ea) begin failures++; $display("FAIL fill_addr[%0d] got=%h exp=%h", k, rd_addr[k], ea); end
            checks++; if (rfw_addr[k] !== 7'(16 + k)) begin failures++; $display("FAIL fill_rf_addr[%0d] got=%0d exp=%0d", k, rfw_addr[k], 16 + k); end
            checks++; if (rfw_data[k] !== (32'hF00D_0000 | ea)) begin failures++; $display("FAIL fill_rf_data[%0d] got=%h exp=%h", k, rfw_data[k], 32'hF00D_0000 | ea); end
        end
        @(negedge Clk);
        checks++; if (cwp !== 5'd0) begin failures++; $display("FAIL fill_cwp got=%0d exp=0", cwp); end
        checks++; if (wim !== 4'b0010) begin failures++; $display("FAIL fill_wim got=%b exp=0010", wim); end
        mfc_delay = 0;
    endtask

    task automatic test_unf_trap();
        int lat;
        issue(0, 1, 0, 5, lat);
        checks++; if (lat !== 1 || unf_trap !== 1'b1) begin failures++; $display("FAIL unf_trap got=%0d/%b exp=1/1", lat, unf_trap); end
        checks++; if (cwp !== 5'd0 || wim !== 4'b0010 || ovf_trap !== 1'b0) begin failures++; $display("FAIL unf_state got=%0d/%b/%b exp=0/0010/0", cwp, wim, ovf_trap); end
    endtask

    task automatic test_reset_abort();
        int lat;
        bit hit;
        apply_reset();
        issue(1, 0, 0, 5, lat);
        issue(1, 0, 0, 5, lat);
        checks++; if (cwp !== 5'd1) begin failures++; $display("FAIL abort_setup_cwp got=%0d exp=1", cwp); end
        wr_addr.delete(); wr_data.delete();
        @(negedge Clk);
        save_req = 1; auto_mode = 1;
        @(negedge Clk);
        save_req = 0; auto_mode = 0;
        hit = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge Clk);
            #2;
            if (mem_en === 1'b1 && wr_addr.size() == 7) begin
                hit = 1;
                break;
            end
        end
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL abort_reach_word7 got=%b exp=1", hit); end
        Reset_n = 0;
        #1;
        checks++; if (mem_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_mem_en got=%b/%b exp=0/0", mem_en, busy); end
        checks++; if (cwp !== 5'd3 || wim !== 4'b0001) begin failures++; $display("FAIL abort_state got=%0d/%b exp=3/0001", cwp, wim); end
        @(negedge Clk);
        Reset_n = 1;
        @(negedge Clk);
        save_req = 1; rest_req = 1;
        @(negedge Clk);
        save_req = 0; rest_req = 0;
        checks++; if (req_err !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL req_err got=%b/%b exp=1/0", req_err, done); end
        checks++; if (cwp !== 5'd3 || busy !== 1'b0) begin failures++; $display("FAIL req_err_state got=%0d/%b exp=3/0", cwp, busy); end
        @(negedge Clk);
        checks++; if (req_err !== 1'b0 || wim !== 4'b0001) begin failures++; $display("FAIL req_err_pulse got=%b/%b exp=0/0001", req_err, wim); end
    endtask

    initial begin
        test_reset();
        test_save_simple();
        test_ovf_trap();
        test_spill();
        test_wim_write();
        test_fill();
        test_unf_trap();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
